reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 8, number of entries; tags are 1..ROB_SIZE and tag 0 means "no dependency".
REQ-002 SHALL have parameter ROB_BIT, default 4, tag width; 2^ROB_BIT > ROB_SIZE.
REQ-003 SHALL have ports: clk input 1 clock; rst input 1 reset (synchronous, active-high); en input 1 global enable.
REQ-004 SHALL have issue ports: is_en_i in 1; is_tp_i in 2 (00 ALU, 01 load, 10 store, 11 branch/jump); is_rd_i in REG_BIT; is_pc_i in DAT_W; is_pred_i in 1 (predicted taken).
REQ-005 SHALL have allocation ports: full_o out 1; rf_qd_o out ROB_BIT, the tag the next issue receives (combinational).
REQ-006 SHALL have completion ports: cdb_en_i, cdb_q_i, cdb_v_i, cdb_br_i (actual taken) and cdb_tgt_i (DAT_W); ldb_en_i, ldb_q_i, ldb_v_i (loads and stores report here).
REQ-007 SHALL have commit ports, all registered: rf_en_o 1; rf_rd_o REG_BIT; rf_q_o ROB_BIT; rf_v_o DAT_W; lsb_commit_o 1; lsb_commit_q_o ROB_BIT.
REQ-008 SHALL have query ports: rf_reqqj_i and rf_reqqk_i in ROB_BIT; rf_rdyj_o and rf_rdyk_o out 1; rf_rdyvj_o and rf_rdyvk_o out DAT_W, all combinational.
REQ-009 SHALL have flush ports: br_flag_o out 1 and br_pc_o out DAT_W, both registered.

Function
REQ-010 SHALL be a circular buffer with head, tail and count (0..ROB_SIZE); entry i carries tag i+1.
REQ-011 SHALL set each entry's fields: busy, ready, tp, rd, pc, pred, value, taken, target.
REQ-012 SHALL drive full_o = (count == ROB_SIZE) and rf_qd_o = tail+1.
REQ-013 SHALL, when en && is_en_i && !full_o, write the tail entry (busy=1, ready=0) and advance tail mod ROB_SIZE.
REQ-014 SHALL ignore an issue while full_o is high, even if a commit frees a slot in the same cycle.
REQ-015 SHALL, on a cdb_en_i match to a busy entry, set ready=1 and latch value, taken and target.
REQ-016 SHALL, on an ldb_en_i match, set ready=1 and latch value.
REQ-017 SHALL process different cdb and ldb tags in the same cycle; if they carry the same tag, cdb wins; a match to a non-busy entry is ignored.
REQ-018 SHALL commit at most one entry per cycle, when en and the head entry is busy && ready; it then clears busy and advances head.
REQ-019 SHALL, on commit of ALU/load/branch, pulse rf_en_o for one cycle with rf_rd_o=rd, rf_q_o=tag, rf_v_o=value; rd=0 is passed through unchanged.
REQ-020 SHALL, on commit of a store, pulse lsb_commit_o with lsb_commit_q_o=tag, and keep rf_en_o at 0.
REQ-021 SHALL, on commit of a branch with taken != pred, also pulse br_flag_o; br_pc_o = target if taken, else pc+4.
REQ-022 SHALL, in the cycle br_flag_o is high, clear all busy bits, set head=tail=count=0, and ignore issue and completion inputs.
REQ-023 SHALL update count by +1 for an accepted issue and -1 for a commit; both in one cycle leave it unchanged.
REQ-024 SHALL drive rf_rdyj_o=1 only when rf_reqqj_i!=0 and entry rf_reqqj_i-1 is busy && ready, with rf_rdyvj_o as its value, else 0; k likewise; there is no same-cycle CDB bypass.
REQ-025 SHALL, while en is low, hold all state and drive all pulse outputs to 0.

Reset
REQ-026 SHALL, on rst, force head=tail=count=0, all busy/ready=0, and all outputs to 0 (full_o=0, rf_qd_o=1).
REQ-027 SHALL have rst take priority over en, issue, completion and flush in the same cycle.

Verification
REQ-028 SHALL cover: issue ALU rd=5 -> tag 1; cdb q=1 v=0x2A -> next cycle rf_en_o=1, rd=5, q=1, v=0x2A; count returns to 0.
REQ-029 SHALL cover: 8 issues, no completions -> full_o=1; 9th issue ignored; complete tag 1 -> commit; next issue gets tag 1 (wrap).
REQ-030 SHALL cover: tags 1,2 issued; cdb q=2 before q=1 -> no commit until tag 1 ready; then tag 1 and tag 2 commit on consecutive cycles.
REQ-031 SHALL cover: branch pc=0x100, pred=0, cdb br=1 tgt=0x200 -> br_flag_o=1, br_pc_o=0x200; next cycle count=0, rf_qd_o=1.
REQ-032 SHALL cover: store tag 3 completes via ldb -> lsb_commit_o=1, q=3, rf_en_o=0; query rf_reqqj_i=4 with entry 4 ready v=7 -> rf_rdyj_o=1, rf_rdyvj_o=7.
REQ-033 SHALL cover: rst asserted with 3 entries pending -> next cycle full_o=0, rf_qd_o=1, and no commit pulses.

Source files
------------

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Purpose  : Circular reorder buffer for an out-of-order core. Instructions
//            are allocated in program order at the tail, completed out of
//            order from the common data bus (cdb) or the load/store bus (ldb),
//            and retired in order from the head at most one per cycle.
//            A retired branch whose outcome differs from its prediction
//            raises a one-cycle flush that empties the buffer.
// Ports    : clk, rst (sync, active-high), en (global enable)
//            is_*      : issue request (type, dest reg, pc, prediction)
//            full_o    : no free entry; rf_qd_o : tag of the next issue
//            cdb_*     : completion with value, actual taken, branch target
//            ldb_*     : load/store completion with value
//            rf_*_o    : registered register-file commit pulse
//            lsb_*_o   : registered store commit pulse to the store buffer
//            rf_reqq*/rf_rdy* : operand lookup by tag (combinational)
//            br_flag_o, br_pc_o : registered flush request and redirect pc
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int ROB_SIZE = 8,
    parameter int ROB_BIT  = 4,
    parameter int REG_BIT  = 5,
    parameter int DAT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    // issue
    input  logic                is_en_i,
    input  logic [1:0]          is_tp_i,
    input  logic [REG_BIT-1:0]  is_rd_i,
    input  logic [DAT_W-1:0]    is_pc_i,
    input  logic                is_pred_i,
    // allocation
    output logic                full_o,
    output logic [ROB_BIT-1:0]  rf_qd_o,
    // completion
    input  logic                cdb_en_i,
    input  logic [ROB_BIT-1:0]  cdb_q_i,
    input  logic [DAT_W-1:0]    cdb_v_i,
    input  logic                cdb_br_i,
    input  logic [DAT_W-1:0]    cdb_tgt_i,
    input  logic                ldb_en_i,
    input  logic [ROB_BIT-1:0]  ldb_q_i,
    input  logic [DAT_W-1:0]    ldb_v_i,
    // commit
    output logic                rf_en_o,
    output logic [REG_BIT-1:0]  rf_rd_o,
    output logic [ROB_BIT-1:0]  rf_q_o,
    output logic [DAT_W-1:0]    rf_v_o,
    output logic                lsb_commit_o,
    output logic [ROB_BIT-1:0]  lsb_commit_q_o,
    // operand query
    input  logic [ROB_BIT-1:0]  rf_reqqj_i,
    input  logic [ROB_BIT-1:0]  rf_reqqk_i,
    output logic                rf_rdyj_o,
    output logic                rf_rdyk_o,
    output logic [DAT_W-1:0]    rf_rdyvj_o,
    output logic [DAT_W-1:0]    rf_rdyvk_o,
    // flush
    output logic                br_flag_o,
    output logic [DAT_W-1:0]    br_pc_o
);

    localparam logic [1:0] c_tp_store  = 2'b10;
    localparam logic [1:0] c_tp_branch = 2'b11;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ROB_BIT-1:0]  r_head;
    logic [ROB_BIT-1:0]  r_tail;
    logic [ROB_BIT-1:0]  r_count;

    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_ready;
    logic [ROB_SIZE-1:0] r_pred;
    logic [ROB_SIZE-1:0] r_taken;
    logic [1:0]          r_tp     [ROB_SIZE];
    logic [REG_BIT-1:0]  r_rd     [ROB_SIZE];
    logic [DAT_W-1:0]    r_pc     [ROB_SIZE];
    logic [DAT_W-1:0]    r_value  [ROB_SIZE];
    logic [DAT_W-1:0]    r_target [ROB_SIZE];

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic                w_full;
    logic                w_live;
    logic                w_issue;
    logic                w_commit;
    logic                w_mispredict;
    logic [ROB_BIT-1:0]  w_head_tag;
    logic [ROB_SIZE-1:0] w_issue_hit;
    logic [ROB_SIZE-1:0] w_commit_hit;
    logic [ROB_SIZE-1:0] w_cdb_hit;
    logic [ROB_SIZE-1:0] w_ldb_hit;

    logic                w_head_busy;
    logic                w_head_ready;
    logic [1:0]          w_head_tp;
    logic [REG_BIT-1:0]  w_head_rd;
    logic [DAT_W-1:0]    w_head_pc;
    logic                w_head_pred;
    logic [DAT_W-1:0]    w_head_value;
    logic                w_head_taken;
    logic [DAT_W-1:0]    w_head_target;

    function automatic logic [ROB_BIT-1:0] f_next(input logic [ROB_BIT-1:0] p);
        return (p == ROB_BIT'(ROB_SIZE - 1)) ? '0 : p + ROB_BIT'(1);
    endfunction

    assign w_full     = (r_count == ROB_BIT'(ROB_SIZE));
    assign full_o     = w_full;
    assign rf_qd_o    = r_tail + ROB_BIT'(1);
    assign w_head_tag = r_head + ROB_BIT'(1);

    // The flush cycle (br_flag_o high) belongs to wrong-path work: nothing
    // is issued, completed or committed while it is pending.
    assign w_live  = en && !br_flag_o;
    // Fullness is judged on the current count, so a same-cycle commit never
    // opens a slot for the issue.
    assign w_issue = w_live && is_en_i && !w_full;

    // Head entry fields, selected by comparison to keep index widths exact.
    always_comb begin
        w_head_busy   = 1'b0;
        w_head_ready  = 1'b0;
        w_head_tp     = '0;
        w_head_rd     = '0;
        w_head_pc     = '0;
        w_head_pred   = 1'b0;
        w_head_value  = '0;
        w_head_taken  = 1'b0;
        w_head_target = '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
            if (r_head == ROB_BIT'(i)) begin
                w_head_busy   = r_busy[i];
                w_head_ready  = r_ready[i];
                w_head_tp     = r_tp[i];
                w_head_rd     = r_rd[i];
                w_head_pc     = r_pc[i];
                w_head_pred   = r_pred[i];
                w_head_value  = r_value[i];
                w_head_taken  = r_taken[i];
                w_head_target = r_target[i];
            end
        end
    end

    assign w_commit     = w_live && w_head_busy && w_head_ready;
    assign w_mispredict = (w_head_tp == c_tp_branch) && (w_head_taken != w_head_pred);

    // Per-entry event decode. A cdb hit shadows an ldb hit on the same tag;
    // completions addressed to idle entries are dropped.
    always_comb begin
        w_issue_hit  = '0;
        w_commit_hit = '0;
        w_cdb_hit    = '0;
        w_ldb_hit    = '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
            w_issue_hit[i]  = w_issue  && (r_tail == ROB_BIT'(i));
            w_commit_hit[i] = w_commit && (r_head == ROB_BIT'(i));
            w_cdb_hit[i]    = w_live && cdb_en_i && r_busy[i] &&
                              (cdb_q_i == ROB_BIT'(i + 1));
            w_ldb_hit[i]    = w_live && ldb_en_i && r_busy[i] &&
                              (ldb_q_i == ROB_BIT'(i + 1)) && !w_cdb_hit[i];
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || br_flag_o) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_issue) begin
                r_tail <= f_next(r_tail);
            end
            if (w_commit) begin
                r_head <= f_next(r_head);
            end
            unique case ({w_issue, w_commit})
                2'b10:   r_count <= r_count + ROB_BIT'(1);
                2'b01:   r_count <= r_count - ROB_BIT'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry status bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || br_flag_o) begin
            r_busy  <= '0;
            r_ready <= '0;
        end else begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (w_commit_hit[i]) begin
                    r_busy[i] <= 1'b0;
                end
                if (w_issue_hit[i]) begin
                    r_busy[i]  <= 1'b1;
                    r_ready[i] <= 1'b0;
                end else if (w_cdb_hit[i] || w_ldb_hit[i]) begin
                    r_ready[i] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry payload. Result fields are cleared at issue so a branch that
    // completes on the ldb reads as not-taken rather than stale data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            if (w_issue_hit[i]) begin
                r_tp[i]     <= is_tp_i;
                r_rd[i]     <= is_rd_i;
                r_pc[i]     <= is_pc_i;
                r_pred[i]   <= is_pred_i;
                r_value[i]  <= '0;
                r_taken[i]  <= 1'b0;
                r_target[i] <= '0;
            end else if (w_cdb_hit[i]) begin
                r_value[i]  <= cdb_v_i;
                r_taken[i]  <= cdb_br_i;
                r_target[i] <= cdb_tgt_i;
            end else if (w_ldb_hit[i]) begin
                r_value[i]  <= ldb_v_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit and flush outputs: pulses carry data only while asserted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_en_o        <= 1'b0;
            rf_rd_o        <= '0;
            rf_q_o         <= '0;
            rf_v_o         <= '0;
            lsb_commit_o   <= 1'b0;
            lsb_commit_q_o <= '0;
            br_flag_o      <= 1'b0;
            br_pc_o        <= '0;
        end else begin
            rf_en_o        <= 1'b0;
            rf_rd_o        <= '0;
            rf_q_o         <= '0;
            rf_v_o         <= '0;
            lsb_commit_o   <= 1'b0;
            lsb_commit_q_o <= '0;
            br_flag_o      <= 1'b0;
            br_pc_o        <= '0;
            if (w_commit) begin
                if (w_head_tp == c_tp_store) begin
                    lsb_commit_o   <= 1'b1;
                    lsb_commit_q_o <= w_head_tag;
                end else begin
                    rf_en_o <= 1'b1;
                    rf_rd_o <= w_head_rd;
                    rf_q_o  <= w_head_tag;
                    rf_v_o  <= w_head_value;
                end
                if (w_mispredict) begin
                    br_flag_o <= 1'b1;
                    br_pc_o   <= w_head_taken ? w_head_target
                                              : w_head_pc + DAT_W'(4);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand lookup; only values already stored are visible.
    // ------------------------------------------------------------------
    always_comb begin
        rf_rdyj_o  = 1'b0;
        rf_rdyk_o  = 1'b0;
        rf_rdyvj_o = '0;
        rf_rdyvk_o = '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
            if ((rf_reqqj_i == ROB_BIT'(i + 1)) && r_busy[i] && r_ready[i]) begin
                rf_rdyj_o  = 1'b1;
                rf_rdyvj_o = r_value[i];
            end
            if ((rf_reqqk_i == ROB_BIT'(i + 1)) && r_busy[i] && r_ready[i]) begin
                rf_rdyk_o  = 1'b1;
                rf_rdyvk_o = r_value[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Purpose  : Self-checking bench for reorder_buffer. A program-order queue
//            of in-flight instructions serves as the reference; directed
//            scenarios pin it with literal values, then random traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int ROB_SIZE = 8;
    localparam int ROB_BIT  = 4;
    localparam int REG_BIT  = 5;
    localparam int DAT_W    = 32;

    logic               clk, rst, en;
    logic               is_en_i, is_pred_i;
    logic [1:0]         is_tp_i;
    logic [REG_BIT-1:0] is_rd_i;
    logic [DAT_W-1:0]   is_pc_i;
    logic               full_o;
    logic [ROB_BIT-1:0] rf_qd_o;
    logic               cdb_en_i, cdb_br_i, ldb_en_i;
    logic [ROB_BIT-1:0] cdb_q_i, ldb_q_i;
    logic [DAT_W-1:0]   cdb_v_i, cdb_tgt_i, ldb_v_i;
    logic               rf_en_o, lsb_commit_o, br_flag_o;
    logic [REG_BIT-1:0] rf_rd_o;
    logic [ROB_BIT-1:0] rf_q_o, lsb_commit_q_o;
    logic [DAT_W-1:0]   rf_v_o, br_pc_o;
    logic [ROB_BIT-1:0] rf_reqqj_i, rf_reqqk_i;
    logic               rf_rdyj_o, rf_rdyk_o;
    logic [DAT_W-1:0]   rf_rdyvj_o, rf_rdyvk_o;

    reorder_buffer #(
        .ROB_SIZE(ROB_SIZE), .ROB_BIT(ROB_BIT), .REG_BIT(REG_BIT), .DAT_W(DAT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .is_en_i(is_en_i), .is_tp_i(is_tp_i), .is_rd_i(is_rd_i),
        .is_pc_i(is_pc_i), .is_pred_i(is_pred_i),
        .full_o(full_o), .rf_qd_o(rf_qd_o),
        .cdb_en_i(cdb_en_i), .cdb_q_i(cdb_q_i), .cdb_v_i(cdb_v_i),
        .cdb_br_i(cdb_br_i), .cdb_tgt_i(cdb_tgt_i),
        .ldb_en_i(ldb_en_i), .ldb_q_i(ldb_q_i), .ldb_v_i(ldb_v_i),
        .rf_en_o(rf_en_o), .rf_rd_o(rf_rd_o), .rf_q_o(rf_q_o), .rf_v_o(rf_v_o),
        .lsb_commit_o(lsb_commit_o), .lsb_commit_q_o(lsb_commit_q_o),
        .rf_reqqj_i(rf_reqqj_i), .rf_reqqk_i(rf_reqqk_i),
        .rf_rdyj_o(rf_rdyj_o), .rf_rdyk_o(rf_rdyk_o),
        .rf_rdyvj_o(rf_rdyvj_o), .rf_rdyvk_o(rf_rdyvk_o),
        .br_flag_o(br_flag_o), .br_pc_o(br_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: in-flight instructions oldest first
    // ------------------------------------------------------------------
    typedef struct {
        int          tag;
        logic [1:0]  tp;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred;
        logic        ready;
        logic [31:0] value;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t rob[$];
    int   next_tag;
    logic        e_rf_en, e_lsb, e_br;
    logic [4:0]  e_rd;
    logic [3:0]  e_q, e_lsb_q;
    logic [31:0] e_v, e_br_pc;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h required 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic clear_exp();
        e_rf_en = 0; e_lsb = 0; e_br = 0;
        e_rd = 0; e_q = 0; e_lsb_q = 0; e_v = 0; e_br_pc = 0;
    endtask

    task automatic query(input logic [3:0] req, output logic rdy, output logic [31:0] v);
        rdy = 0; v = 0;
        foreach (rob[i])
            if (req != 0 && rob[i].tag == int'(req) && rob[i].ready) begin
                rdy = 1; v = rob[i].value;
            end
    endtask

    // Advance the model over one clock edge using the inputs now applied.
    task automatic model_step();
        logic flushing;
        bit   can_issue;
        ent_t e;
        flushing = e_br;
        if (rst || flushing) begin
            rob.delete();
            next_tag = 1;
            clear_exp();
        end else if (!en) begin
            clear_exp();
        end else begin
            clear_exp();
            can_issue = (rob.size() < ROB_SIZE);
            if (rob.size() > 0 && rob[0].ready) begin
                e = rob.pop_front();
                if (e.tp == 2'b10) begin
                    e_lsb = 1; e_lsb_q = 4'(e.tag);
                end else begin
                    e_rf_en = 1; e_rd = e.rd; e_q = 4'(e.tag); e_v = e.value;
                end
                if (e.tp == 2'b11 && e.taken != e.pred) begin
                    e_br = 1;
                    e_br_pc = e.taken ? e.target : e.pc + 32'd4;
                end
            end
            foreach (rob[i]) begin
                if (cdb_en_i && rob[i].tag == int'(cdb_q_i)) begin
                    rob[i].ready = 1; rob[i].value = cdb_v_i;
                    rob[i].taken = cdb_br_i; rob[i].target = cdb_tgt_i;
                end else if (ldb_en_i && rob[i].tag == int'(ldb_q_i)) begin
                    rob[i].ready = 1; rob[i].value = ldb_v_i;
                end
            end
            if (is_en_i && can_issue) begin
                e.tag = next_tag; e.tp = is_tp_i; e.rd = is_rd_i; e.pc = is_pc_i;
                e.pred = is_pred_i; e.ready = 0; e.value = 0; e.taken = 0; e.target = 0;
                rob.push_back(e);
                next_tag = (next_tag == ROB_SIZE) ? 1 : next_tag + 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic        rdy;
        logic [31:0] v;
        chk("full_o", 32'(full_o), 32'(rob.size() == ROB_SIZE));
        chk("rf_qd_o", 32'(rf_qd_o), 32'(next_tag));
        chk("rf_en_o", 32'(rf_en_o), 32'(e_rf_en));
        chk("rf_rd_o", 32'(rf_rd_o), 32'(e_rd));
        chk("rf_q_o", 32'(rf_q_o), 32'(e_q));
        chk("rf_v_o", rf_v_o, e_v);
        chk("lsb_commit_o", 32'(lsb_commit_o), 32'(e_lsb));
        chk("lsb_commit_q_o", 32'(lsb_commit_q_o), 32'(e_lsb_q));
        chk("br_flag_o", 32'(br_flag_o), 32'(e_br));
        chk("br_pc_o", br_pc_o, e_br_pc);
        query(rf_reqqj_i, rdy, v);
        chk("rf_rdyj_o", 32'(rf_rdyj_o), 32'(rdy));
        chk("rf_rdyvj_o", rf_rdyvj_o, v);
        query(rf_reqqk_i, rdy, v);
        chk("rf_rdyk_o", 32'(rf_rdyk_o), 32'(rdy));
        chk("rf_rdyvk_o", rf_rdyvk_o, v);
    endtask

    task automatic idle_inputs();
        rst = 0; en = 1;
        is_en_i = 0; is_tp_i = 0; is_rd_i = 0; is_pc_i = 0; is_pred_i = 0;
        cdb_en_i = 0; cdb_q_i = 0; cdb_v_i = 0; cdb_br_i = 0; cdb_tgt_i = 0;
        ldb_en_i = 0; ldb_q_i = 0; ldb_v_i = 0;
        rf_reqqj_i = 0; rf_reqqk_i = 0;
    endtask

    // Called at a falling edge with inputs applied: compare, step, advance.
    task automatic tick();
        #1;
        check_outputs();
        model_step();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic issue(input logic [1:0] tp, input logic [4:0] rd,
                         input logic [31:0] pc, input logic pred);
        is_en_i = 1; is_tp_i = tp; is_rd_i = rd; is_pc_i = pc; is_pred_i = pred;
    endtask

    task automatic cdb(input logic [3:0] q, input logic [31:0] v,
                       input logic br, input logic [31:0] tgt);
        cdb_en_i = 1; cdb_q_i = q; cdb_v_i = v; cdb_br_i = br; cdb_tgt_i = tgt;
    endtask

    task automatic ldb(input logic [3:0] q, input logic [31:0] v);
        ldb_en_i = 1; ldb_q_i = q; ldb_v_i = v;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        rob.delete();
        next_tag = 1;
        clear_exp();
        repeat (2) @(negedge clk);
        idle_inputs();

        // Reset state
        chk("reset full_o", 32'(full_o), 0);
        chk("reset rf_qd_o", 32'(rf_qd_o), 1);
        chk("reset rf_en_o", 32'(rf_en_o), 0);
        chk("reset br_flag_o", 32'(br_flag_o), 0);

        // ALU issue, cdb completion, commit
        issue(2'b00, 5, 32'h0, 0);
        chk("first tag", 32'(rf_qd_o), 1);
        tick();
        cdb(1, 32'h2A, 0, 0); tick();
        tick();
        chk("alu rf_en_o", 32'(rf_en_o), 1);
        chk("alu rf_rd_o", 32'(rf_rd_o), 5);
        chk("alu rf_q_o", 32'(rf_q_o), 1);
        chk("alu rf_v_o", rf_v_o, 32'h2A);
        chk("alu model empty", 32'(rob.size()), 0);
        tick();

        // Fill, overflow, wrap, and no issue into a slot freed the same cycle
        do_reset();
        for (int i = 0; i < ROB_SIZE; i++) begin
            issue(2'b00, 5'(i + 1), 32'(i * 4), 0);
            tick();
        end
        chk("full after 8", 32'(full_o), 1);
        issue(2'b00, 9, 32'h40, 0); tick();
        chk("9th ignored full", 32'(full_o), 1);
        chk("9th ignored model", 32'(rob.size()), ROB_SIZE);
        cdb(1, 32'h11, 0, 0); tick();
        issue(2'b00, 20, 32'h50, 0); tick();
        chk("commit-cycle issue dropped", 32'(full_o), 0);
        chk("wrap rf_qd_o", 32'(rf_qd_o), 1);
        chk("wrap commit q", 32'(rf_q_o), 1);
        issue(2'b00, 21, 32'h54, 0); tick();
        chk("wrap refill full", 32'(full_o), 1);
        chk("wrap tag model", 32'(rob[$].tag), 1);

        // Out-of-order completion, in-order commit
        do_reset();
        issue(2'b00, 1, 0, 0); tick();
        issue(2'b00, 2, 4, 0); tick();
        cdb(2, 32'h22, 0, 0); tick();
        tick();
        chk("ooo no early commit", 32'(rf_en_o), 0);
        cdb(1, 32'h11, 0, 0); tick();
        tick();
        chk("ooo commit1 q", 32'(rf_q_o), 1);
        tick();
        chk("ooo commit2 en", 32'(rf_en_o), 1);
        chk("ooo commit2 q", 32'(rf_q_o), 2);
        chk("ooo commit2 v", rf_v_o, 32'h22);

        // Mispredicted taken branch, then mispredicted not-taken branch
        do_reset();
        issue(2'b11, 1, 32'h100, 0); tick();
        issue(2'b00, 3, 32'h104, 0); tick();
        cdb(1, 32'h104, 1, 32'h200); tick();
        tick();
        chk("br taken flag", 32'(br_flag_o), 1);
        chk("br taken pc", br_pc_o, 32'h200);
        tick();
        chk("flush rf_qd_o", 32'(rf_qd_o), 1);
        chk("flush full_o", 32'(full_o), 0);
        chk("flush model empty", 32'(rob.size()), 0);
        issue(2'b11, 1, 32'h300, 1); tick();
        cdb(1, 0, 0, 32'h999); tick();
        tick();
        chk("br nt flag", 32'(br_flag_o), 1);
        chk("br nt pc", br_pc_o, 32'h304);
        tick();

        // Store commit via ldb and operand query
        do_reset();
        issue(2'b00, 1, 0, 0); tick();
        issue(2'b01, 2, 4, 0); tick();
        issue(2'b10, 0, 8, 0); tick();
        issue(2'b00, 4, 12, 0); tick();
        cdb(1, 1, 0, 0); ldb(2, 2); tick();
        cdb(4, 7, 0, 0); ldb(3, 32'h33); tick();
        tick();
        rf_reqqj_i = 4; rf_reqqk_i = 1;
        #1;
        chk("query j rdy", 32'(rf_rdyj_o), 1);
        chk("query j val", rf_rdyvj_o, 7);
        chk("query k retired", 32'(rf_rdyk_o), 0);
        tick();
        chk("store lsb_commit_o", 32'(lsb_commit_o), 1);
        chk("store lsb_commit_q_o", 32'(lsb_commit_q_o), 3);
        chk("store rf_en_o", 32'(rf_en_o), 0);
        tick();

        // Reset with entries pending and a commit about to happen
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(2'b00, 5'(i + 1), 32'(i * 4), 0);
            tick();
        end
        cdb(1, 32'h55, 0, 0); tick();
        rst = 1; tick();
        chk("rst full_o", 32'(full_o), 0);
        chk("rst rf_qd_o", 32'(rf_qd_o), 1);
        chk("rst rf_en_o", 32'(rf_en_o), 0);
        chk("rst lsb_commit_o", 32'(lsb_commit_o), 0);
        chk("rst br_flag_o", 32'(br_flag_o), 0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            is_en_i   = ($urandom_range(0, 2) != 0);
            is_tp_i   = 2'($urandom_range(0, 3));
            is_rd_i   = 5'($urandom);
            is_pc_i   = $urandom & 32'hFFFF_FFFC;
            is_pred_i = 1'($urandom);
            cdb_en_i  = 1'($urandom);
            cdb_q_i   = 4'($urandom_range(0, 9));
            cdb_v_i   = $urandom;
            cdb_br_i  = 1'($urandom);
            cdb_tgt_i = $urandom;
            ldb_en_i  = 1'($urandom);
            ldb_q_i   = ($urandom_range(0, 7) == 0) ? cdb_q_i : 4'($urandom_range(0, 9));
            ldb_v_i   = $urandom;
            rf_reqqj_i = 4'($urandom_range(0, 9));
            rf_reqqk_i = 4'($urandom_range(0, 9));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
